// File: rtl/wb_timer_if.sv
// Wishbone slave-side bus bundle for the wb_timer peripheral.
// Signal names keep the direction suffix as seen from the slave.
interface wb_timer_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_timer.sv
// wb_timer: two up-counting timers sharing one prescaler, behind a
// Wishbone slave port. Each timer has compare match, optional auto-reload
// and a level interrupt (TRIG & IRQEN). Every bus access takes two cycles.
module wb_timer #(
    parameter int counter_width  = 32,
    parameter int prescale_width = 16
) (
    input  logic       clk,
    input  logic       rst,
    wb_timer_if.slave  wb,
    output logic [1:0] intr
);
    localparam int CW = counter_width;
    localparam int PW = prescale_width;

    localparam logic [2:0] ADR_PRE = 3'd6;

    // Byte-lane merge of write data into an existing register image.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Zero-extend a counter/compare value to the bus width.
    function automatic logic [31:0] cnt_ext(input logic [CW-1:0] v);
        logic [31:0] res;
        res = 32'd0;
        res[CW-1:0] = v;
        return res;
    endfunction

    // Zero-extend the prescale value to the bus width.
    function automatic logic [31:0] pre_ext(input logic [PW-1:0] v);
        logic [31:0] res;
        res = 32'd0;
        res[PW-1:0] = v;
        return res;
    endfunction

    // Register-select codes of timer n: TCR, COMPARE, COUNTER.
    function automatic logic [2:0] tcr_adr(input int n);
        return (n == 0) ? 3'd0 : 3'd3;
    endfunction
    function automatic logic [2:0] cmp_adr(input int n);
        return (n == 0) ? 3'd1 : 3'd4;
    endfunction
    function automatic logic [2:0] cnt_adr(input int n);
        return (n == 0) ? 3'd2 : 3'd5;
    endfunction

    // State
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [1:0]    en_q, en_d, ar_q, ar_d, irqen_q, irqen_d, trig_q, trig_d;
    logic [CW-1:0] cmp_q [2];
    logic [CW-1:0] cmp_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [PW-1:0] pre_q, pre_d, pc_q, pc_d;

    // Combinational helpers
    logic          access_s, wr_s, tick_s, pre_wr_s;
    logic [2:0]    reg_sel_s;
    logic [1:0]    tcr_hit_s, cnt_wr_s, cmp_wr_s, match_s;
    logic [31:0]   cmp_wdata_s [2];
    logic [31:0]   cnt_wdata_s [2];
    logic [31:0]   pre_wdata_s;
    logic [31:0]   rd_s;
    logic          unused_s;

    // Undecoded address bits and merged bits above the register widths.
    assign unused_s = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], pre_wdata_s,
                        cmp_wdata_s[0], cmp_wdata_s[1], cnt_wdata_s[0], cnt_wdata_s[1]};

    // Bus access decode and prescaler tick.
    always_comb begin
        access_s  = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
        wr_s      = access_s & wb.wb_we_i;
        reg_sel_s = wb.wb_adr_i[4:2];
        pre_wr_s  = wr_s & (reg_sel_s == ADR_PRE);
        tick_s    = (pc_q == pre_q);
    end

    // Write data merged per byte lane with each target's current value.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            cmp_wdata_s[n] = lane_merge(cnt_ext(cmp_q[n]), wb.wb_dat_i, wb.wb_sel_i);
            cnt_wdata_s[n] = lane_merge(cnt_ext(cnt_q[n]), wb.wb_dat_i, wb.wb_sel_i);
        end
        pre_wdata_s = lane_merge(pre_ext(pre_q), wb.wb_dat_i, wb.wb_sel_i);
    end

    // Timer next state: bus writes take priority over tick-driven updates,
    // except a match still sets TRIG over a simultaneous write-1-to-clear.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            tcr_hit_s[n] = wr_s & (reg_sel_s == tcr_adr(n)) & wb.wb_sel_i[0];
            cmp_wr_s[n]  = wr_s & (reg_sel_s == cmp_adr(n));
            cnt_wr_s[n]  = wr_s & (reg_sel_s == cnt_adr(n));
            match_s[n]   = tick_s & en_q[n] & ~cnt_wr_s[n] & (cnt_q[n] == cmp_q[n]);

            if (cnt_wr_s[n]) begin
                cnt_d[n] = cnt_wdata_s[n][CW-1:0];
            end else if (tick_s & en_q[n]) begin
                if (match_s[n]) begin
                    cnt_d[n] = {CW{1'b0}};
                end else begin
                    cnt_d[n] = cnt_q[n] + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_d[n] = cnt_q[n];
            end

            if (cmp_wr_s[n]) begin
                cmp_d[n] = cmp_wdata_s[n][CW-1:0];
            end else begin
                cmp_d[n] = cmp_q[n];
            end

            if (tcr_hit_s[n]) begin
                en_d[n]    = wb.wb_dat_i[0];
                ar_d[n]    = wb.wb_dat_i[1];
                irqen_d[n] = wb.wb_dat_i[2];
            end else begin
                en_d[n]    = (match_s[n] & ~ar_q[n]) ? 1'b0 : en_q[n];
                ar_d[n]    = ar_q[n];
                irqen_d[n] = irqen_q[n];
            end

            if (match_s[n]) begin
                trig_d[n] = 1'b1;
            end else if (tcr_hit_s[n] & wb.wb_dat_i[3]) begin
                trig_d[n] = 1'b0;
            end else begin
                trig_d[n] = trig_q[n];
            end
        end
    end

    // Prescaler: counts 0..PRESCALE and restarts whenever PRESCALE is written.
    always_comb begin
        if (pre_wr_s) begin
            pre_d = pre_wdata_s[PW-1:0];
        end else begin
            pre_d = pre_q;
        end
        if (pre_wr_s | tick_s) begin
            pc_d = {PW{1'b0}};
        end else begin
            pc_d = pc_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Read mux and handshake: data is presented only in the ack cycle.
    always_comb begin
        case (reg_sel_s)
            3'd0:    rd_s = {28'd0, trig_q[0], irqen_q[0], ar_q[0], en_q[0]};
            3'd1:    rd_s = cnt_ext(cmp_q[0]);
            3'd2:    rd_s = cnt_ext(cnt_q[0]);
            3'd3:    rd_s = {28'd0, trig_q[1], irqen_q[1], ar_q[1], en_q[1]};
            3'd4:    rd_s = cnt_ext(cmp_q[1]);
            3'd5:    rd_s = cnt_ext(cnt_q[1]);
            3'd6:    rd_s = pre_ext(pre_q);
            3'd7:    rd_s = 32'd0;
            default: rd_s = 32'd0;
        endcase
        ack_d = access_s;
        if (access_s & ~wb.wb_we_i) begin
            dat_d = rd_s;
        end else begin
            dat_d = 32'd0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            en_q    <= 2'b00;
            ar_q    <= 2'b00;
            irqen_q <= 2'b00;
            trig_q  <= 2'b00;
            pre_q   <= {PW{1'b0}};
            pc_q    <= {PW{1'b0}};
            for (int n = 0; n < 2; n++) begin
                cmp_q[n] <= {CW{1'b0}};
                cnt_q[n] <= {CW{1'b0}};
            end
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            ar_q    <= ar_d;
            irqen_q <= irqen_d;
            trig_q  <= trig_d;
            pre_q   <= pre_d;
            pc_q    <= pc_d;
            for (int n = 0; n < 2; n++) begin
                cmp_q[n] <= cmp_d[n];
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    // Level interrupt follows TRIG with no added delay.
    assign intr = trig_q & irqen_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: a memory-map reference model is stepped
// every clock and compared against ack/dat_o/intr on every falling edge;
// directed sequences pin the model with hand-computed literals.
module tb_wb_timer;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] intr;

    wb_timer_if wbi();

    wb_timer dut (
        .clk  (clk),
        .rst  (rst),
        .wb   (wbi),
        .intr (intr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model: register map as 8 words ----------------
    logic [31:0] m_reg [0:7];
    logic        m_ack = 1'b0;
    logic [31:0] m_dat = 32'd0;
    int          m_phase = 0;
    bit          m_valid = 1'b0;

    initial begin : model
        logic [31:0] nx [0:7];
        logic [31:0] merged, tcr;
        logic        acc, wr, tick, fires, twr, cwr, en, ar, irq, trig;
        logic [2:0]  a, base;
        int          pre;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
                m_ack = 1'b0;
                m_dat = 32'd0;
                m_phase = 0;
                m_valid = 1'b1;
            end else begin
                acc  = wbi.wb_stb_i && wbi.wb_cyc_i && !m_ack;
                wr   = acc && wbi.wb_we_i;
                a    = wbi.wb_adr_i[4:2];
                pre  = int'(m_reg[6]);
                tick = ((m_phase % (pre + 1)) == pre);
                merged = m_reg[a];
                for (int b = 0; b < 4; b++)
                    if (wbi.wb_sel_i[b]) merged[8*b +: 8] = wbi.wb_dat_i[8*b +: 8];
                nx = m_reg;
                for (int n = 0; n < 2; n++) begin
                    base  = 3'(3 * n);
                    tcr   = m_reg[base];
                    twr   = wr && (a == base) && wbi.wb_sel_i[0];
                    cwr   = wr && (a == base + 3'd2);
                    fires = tick && tcr[0] && !cwr && (m_reg[base + 3'd2] == m_reg[base + 3'd1]);
                    if (cwr) nx[base + 3'd2] = merged;
                    else if (tick && tcr[0]) nx[base + 3'd2] = fires ? 32'd0 : m_reg[base + 3'd2] + 32'd1;
                    if (wr && (a == base + 3'd1)) nx[base + 3'd1] = merged;
                    en   = twr ? wbi.wb_dat_i[0] : ((fires && !tcr[1]) ? 1'b0 : tcr[0]);
                    ar   = twr ? wbi.wb_dat_i[1] : tcr[1];
                    irq  = twr ? wbi.wb_dat_i[2] : tcr[2];
                    trig = fires ? 1'b1 : ((twr && wbi.wb_dat_i[3]) ? 1'b0 : tcr[3]);
                    nx[base] = {28'd0, trig, irq, ar, en};
                end
                if (wr && a == 3'd6) begin
                    nx[6] = merged & 32'h0000_FFFF;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
                m_dat = (acc && !wbi.wb_we_i) ? m_reg[a] : 32'd0;
                m_ack = acc;
                m_reg = nx;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("ack", {31'd0, wbi.wb_ack_o}, {31'd0, m_ack});
            check("dat_o", wbi.wb_dat_o, m_dat);
            check("intr", {30'd0, intr},
                  {30'd0, m_reg[3][3] & m_reg[3][2], m_reg[0][3] & m_reg[0][2]});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic xfer(input logic we, input logic [4:0] off, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] rdata);
        bit got;
        wbi.wb_adr_i = 32'hF001_0000 | {27'd0, off};
        wbi.wb_dat_i = d;
        wbi.wb_sel_i = sel;
        wbi.wb_we_i  = we;
        wbi.wb_stb_i = 1'b1;
        wbi.wb_cyc_i = 1'b1;
        rdata = 32'd0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (wbi.wb_ack_o) begin
                got = 1'b1;
                rdata = wbi.wb_dat_o;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        wbi.wb_stb_i = 1'b0;
        wbi.wb_cyc_i = 1'b0;
        wbi.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        xfer(1'b1, off, d, sel, dummy);
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] rdata);
        xfer(1'b0, off, 32'd0, 4'hF, rdata);
    endtask

    task automatic wait_intr(input int bit_n, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (intr[bit_n]) seen = 1'b1;
        end
        if (!seen) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_until(input int target);
        while (cyc_cnt < target) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] r;
        int c;
        logic [4:0] off;
        logic [31:0] d;
        logic [3:0] sel;

        rst = 1'b1;
        wbi.wb_adr_i = 32'd0;
        wbi.wb_dat_i = 32'd0;
        wbi.wb_sel_i = 4'h0;
        wbi.wb_we_i  = 1'b0;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_cyc_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ack", {31'd0, wbi.wb_ack_o}, 32'd0);
        check("reset_intr", {30'd0, intr}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(5'(4 * i), r);
            check("reset_reg", r, 32'd0);
        end

        // One-shot with interrupt, tick every cycle.
        wr(5'h18, 32'd0, 4'hF);
        wr(5'h04, 32'd9, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        c = cyc_cnt;
        wait_intr(0, "oneshot_timeout");
        check("oneshot_delay", 32'(cyc_cnt - c), 32'd10);
        rd(5'h00, r);
        check("oneshot_tcr0", r, 32'h0000_000C);
        rd(5'h08, r);
        check("oneshot_cnt0", r, 32'd0);
        wr(5'h00, 32'h8, 4'hF);
        check("oneshot_clr_intr", {31'd0, intr[0]}, 32'd0);

        // Auto-reload with prescaler: period (4+1)*(3+1) = 20.
        wr(5'h18, 32'd3, 4'hF);
        wr(5'h10, 32'd4, 4'hF);
        wr(5'h0C, 32'h7, 4'hF);
        wait_intr(1, "ar_first_timeout");
        c = cyc_cnt;
        wr(5'h0C, 32'hF, 4'hF);
        check("ar_cleared", {31'd0, intr[1]}, 32'd0);
        wait_intr(1, "ar_second_timeout");
        check("ar_period", 32'(cyc_cnt - c), 32'd20);
        rd(5'h0C, r);
        check("ar_tcr1", r, 32'h0000_000F);
        wr(5'h0C, 32'h8, 4'hF);

        // Byte-lane write.
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h04, 32'h0000_1200, 4'b0010);
        rd(5'h04, r);
        check("byte_lane", r, 32'hFFFF_12FF);

        // TRIG set vs write-1-to-clear in the same cycle.
        wr(5'h18, 32'd0, 4'hF);
        wr(5'h04, 32'd5, 4'hF);
        wr(5'h08, 32'd0, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        c = cyc_cnt;
        wait_until(c + 5);
        wr(5'h00, 32'hD, 4'hF);
        check("collide_intr", {31'd0, intr[0]}, 32'd1);
        rd(5'h00, r);
        check("collide_tcr0", r, 32'h0000_000D);
        wr(5'h00, 32'h8, 4'hF);

        // COUNTER write coinciding with a tick.
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h00, 32'h1, 4'hF);
        wr(5'h18, 32'd7, 4'hF);
        c = cyc_cnt;
        wait_until(c + 7);
        wr(5'h08, 32'h55, 4'hF);
        rd(5'h08, r);
        check("cnt_write_tick", r, 32'h0000_0055);
        wr(5'h00, 32'h8, 4'hF);

        // Handshake pattern with strobe held.
        @(negedge clk);
        wbi.wb_adr_i = 32'hF001_001C;
        wbi.wb_we_i  = 1'b0;
        wbi.wb_sel_i = 4'hF;
        wbi.wb_stb_i = 1'b1;
        wbi.wb_cyc_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("hs_ack", {31'd0, wbi.wb_ack_o}, 32'(i % 2));
            if (wbi.wb_ack_o) check("hs_rd_1c", wbi.wb_dat_o, 32'd0);
            @(negedge clk);
        end
        wbi.wb_cyc_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_cyc_ack", {31'd0, wbi.wb_ack_o}, 32'd0);
        end
        wbi.wb_stb_i = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            off = 5'(4 * $urandom_range(0, 7));
            case (off)
                5'h18:          d = 32'($urandom_range(0, 3));
                5'h00, 5'h0C:   d = 32'($urandom_range(0, 15));
                5'h1C:          d = $urandom;
                default:        d = 32'($urandom_range(0, 12));
            endcase
            sel = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            xfer(1'($urandom_range(0, 1)), off, d, sel, r);
            repeat ($urandom_range(0, 3)) begin
                wbi.wb_stb_i = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            wbi.wb_stb_i = 1'b0;
        end

        // Reset during a pending access.
        wbi.wb_adr_i = 32'hF001_0000;
        wbi.wb_stb_i = 1'b1;
        wbi.wb_cyc_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'd0, wbi.wb_ack_o}, 32'd0);
        rst = 1'b0;
        wbi.wb_stb_i = 1'b0;
        wbi.wb_cyc_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone slave timer peripheral occupying interconnect slave 4 at 0xF001xxxx.
- Sits directly downstream of the Wishbone interconnect, alongside uart0.
- Provides two independent up-counting timers sharing one prescaler, each with compare match, optional auto-reload and a level interrupt.
- Interrupt outputs feed the CPU interrupt_n vector (active-low inversion happens at system level).

Parameters:
- counter_width, 32, width of COUNTERn and COMPAREn; bits above counter_width read 0 and ignore writes (valid range 8..32).
- prescale_width, 16, width of PRESCALE register and internal prescale counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wb_adr_i  in  32  byte address; only bits [4:2] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_sel_i  in  4  byte enables for writes
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  acknowledge
- intr  out  2  per-timer interrupt, active-high level

Behaviour:
- Reset is synchronous, clock is clk. On rst: all registers 0, wb_ack_o=0, wb_dat_o=0, intr=0, prescale counter=0.
- Register map, by offset and wb_adr_i[4:2]:
  - 0x00 TCR0: bit0 EN, bit1 AR, bit2 IRQEN, bit3 TRIG (write-1-to-clear), other bits read 0.
  - 0x04 COMPARE0.
  - 0x08 COUNTER0.
  - 0x0C TCR1.
  - 0x10 COMPARE1.
  - 0x14 COUNTER1.
  - 0x18 PRESCALE.
  - 0x1C reads 0, writes ignored.
- Wishbone access:
  - On stb&cyc&!ack: ack=1 next cycle, then ack=0 the following cycle. Every access takes 2 cycles; no back-to-back acks.
  - Read data is registered and valid in the ack cycle. wb_dat_o=0 when ack=0.
  - Writes commit on the same edge that asserts ack and honour wb_sel_i per byte.
  - No err/rty generated.
- Prescaler:
  - Internal counter pc counts 0..PRESCALE, producing tick=1 in the cycle where pc==PRESCALE, then pc wraps to 0.
  - PRESCALE=0 gives tick every cycle.
  - Writing PRESCALE resets pc to 0.
- Timer n, evaluated on each tick while EN=1:
  - If COUNTERn==COMPAREn: COUNTERn<=0, TRIG<=1, and if AR=0 then EN<=0.
  - Otherwise COUNTERn<=COUNTERn+1, wrapping modulo 2^counter_width.
  - Period is therefore (COMPAREn+1)*(PRESCALE+1) cycles. COMPARE=0 matches on every tick.
- EN=0: counter holds value.
- intr[n] = TRIG_n & IRQEN_n, combinational from registers, so it follows TRIG with 0-cycle delay.
- Simultaneous events:
  - A write to COUNTERn in the same cycle as a tick: the write wins, no increment or match that cycle.
  - A TRIG set by a match and a write-1-to-clear in the same cycle: set wins (TRIG stays 1).
  - A TCR write of EN/AR/IRQEN and a match-clearing of EN in the same cycle: the written EN value wins.
- Writing TCR with TRIG bit=0 leaves TRIG unchanged.
- rst mid-transaction drops ack immediately next cycle; the master must retry.

Test Plan:
- Reset: assert rst 2 cycles -> intr=0, ack=0, all 7 registers read 0x00000000.
- One-shot, IRQ: PRESCALE=0, COMPARE0=9, TCR0=0x5 -> intr[0] rises exactly 10 cycles after the enable write commits, EN reads 0, COUNTER0 reads 0. Write TCR0=0x8 -> intr[0]=0.
- Auto-reload with prescaler: PRESCALE=3, COMPARE1=4, TCR1=0x7 -> TRIG1 set every 20 cycles. Clearing TRIG1 between matches re-sets it at the next period boundary; EN stays 1.
- Byte-lane write: COMPARE0=0xFFFFFFFF, then write 0x00001200 with sel=0b0010 -> COMPARE0 reads 0xFFFF12FF.
- Collision: with TRIG0 about to set at a match, write TCR0=0x0D in that exact cycle -> TRIG0 reads 1, intr[0]=1. Writing COUNTER0=0x55 during a tick -> reads 0x55 the next read.
- Handshake: hold stb&cyc high 6 cycles -> ack pattern 0,1,0,1,0,1. Read of 0x1C returns 0. No ack without cyc.
